mem_port_arbiter: RTL and testbench

//  Shares the single 8-bit synchronous RAM port between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, size codes and helpers for the RAM port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DONE} arb_state_t;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    // index of the last byte of an access; 11 falls through to word
    function automatic logic [1:0] size_last(input logic [1:0] size);
        return size == SIZE_B ? 2'd0 : size == SIZE_H ? 2'd1 : 2'd3;
    endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-request round-robin pick; the history flag only moves when both requests contend
module rr_pick2 #(
    parameter bit LS_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_b
);
    logic last_b;
    assign gnt_b = req_b && (!req_a || !last_b);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_b <= !LS_FIRST;
        else if (en && req_a && req_b)
            last_b <= gnt_b;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 8-bit RAM port between instruction fetch and load/store,
// serialising 1/2/4-byte accesses into byte cycles with little-endian assembly.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit LS_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_ack,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy
);
    arb_state_t  state;
    logic        sel_ls;
    logic        we_q;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] buf_nxt;
    logic [7:0]  wbyte;
    logic        take;
    logic        gnt_ls;

    assign take = state == ARB_IDLE && (if_req || ls_req);
    assign busy = state != ARB_IDLE;

    rr_pick2 #(.LS_FIRST(LS_FIRST)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy && take),
        .req_a (if_req),
        .req_b (ls_req),
        .gnt_b (gnt_ls)
    );

    always_comb begin
        buf_nxt = buf_q;
        case (cnt)
            2'd0: buf_nxt[7:0]   = mem_din;
            2'd1: buf_nxt[15:8]  = mem_din;
            2'd2: buf_nxt[23:16] = mem_din;
            default: buf_nxt[31:24] = mem_din;
        endcase
    end

    // next write byte is lane cnt+1
    always_comb begin
        wbyte = wdata_q[31:24];
        case (cnt)
            2'd0: wbyte = wdata_q[15:8];
            2'd1: wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            sel_ls   <= 1'b0;
            we_q     <= 1'b0;
            cnt      <= 2'd0;
            last     <= 2'd0;
            wdata_q  <= ZERO_WORD;
            buf_q    <= ZERO_WORD;
            if_rdata <= ZERO_WORD;
            ls_rdata <= ZERO_WORD;
            if_ack   <= 1'b0;
            ls_ack   <= 1'b0;
            mem_dout <= 8'h00;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
        end else if (rdy) begin
            case (state)
                ARB_IDLE: if (take) begin
                    sel_ls  <= gnt_ls;
                    we_q    <= gnt_ls && ls_we;
                    last    <= gnt_ls ? size_last(ls_size) : 2'd3;
                    wdata_q <= ls_wdata;
                    buf_q   <= ZERO_WORD;
                    cnt     <= 2'd0;
                    mem_a   <= gnt_ls ? ls_addr : if_addr;
                    mem_wr  <= gnt_ls && ls_we;
                    if (gnt_ls && ls_we)
                        mem_dout <= ls_wdata[7:0];
                    state   <= ARB_XFER;
                end
                ARB_XFER: begin
                    if (!we_q)
                        buf_q <= buf_nxt;
                    if (cnt == last) begin
                        mem_wr <= 1'b0;
                        mem_a  <= '0;
                        if_ack <= !sel_ls;
                        ls_ack <= sel_ls;
                        if (!we_q && sel_ls)
                            ls_rdata <= buf_nxt;
                        if (!we_q && !sel_ls)
                            if_rdata <= buf_nxt;
                        state  <= ARB_DONE;
                    end else begin
                        cnt   <= cnt + 2'd1;
                        mem_a <= mem_a + 1'b1;
                        if (we_q)
                            mem_dout <= wbyte;
                    end
                end
                default: begin
                    if_ack <= 1'b0;
                    ls_ack <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed byte-serial RAM port arbiter scenarios with a 4 KiB RAM model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy;
    logic [7:0]  ram [4096];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
    );

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk)
        if (rdy && mem_wr)
            ram[mem_a[11:0]] <= mem_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h101] = 8'h05;
        ram[12'h235] = 8'h5A;
        ram[12'hFFF] = 8'h80;
        ram[12'h000] = 8'hFF;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_acks", {30'b0, if_ack, ls_ack}, 0);
        rst = 1'b0;
        tick();
        // IF word read from 0x100
        if_req = 1'b1;
        if_addr = 32'h100;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("if_rd_mem_a", mem_a, 32'h100 + k - 1);
            chk("if_rd_no_ack", {31'b0, if_ack}, 0);
        end
        tick();
        chk("if_rd_ack", {31'b0, if_ack}, 1);
        chk("if_rd_data", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        chk("if_rd_ack_drop", {31'b0, if_ack}, 0);
        chk("if_rd_idle", {31'b0, busy}, 0);
        // LS byte write 0x1234
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_size = 2'b00;
        ls_addr = 32'h1234;
        ls_wdata = 32'hAABB_CCDD;
        tick();
        ls_wdata = 32'h0;
        chk("sb_mem_wr", {31'b0, mem_wr}, 1);
        chk("sb_mem_a", mem_a, 32'h1234);
        chk("sb_mem_dout", {24'b0, mem_dout}, 32'hDD);
        chk("sb_no_ack", {31'b0, ls_ack}, 0);
        tick();
        chk("sb_ack", {31'b0, ls_ack}, 1);
        chk("sb_wr_off", {31'b0, mem_wr}, 0);
        chk("sb_ram_lo", {24'b0, ram[12'h234]}, 32'hDD);
        chk("sb_ram_hi", {24'b0, ram[12'h235]}, 32'h5A);
        ls_req = 1'b0;
        ls_we = 1'b0;
        tick();
        // contention round 1: LS first
        if_req = 1'b1;
        if_addr = 32'h100;
        ls_req = 1'b1;
        ls_addr = 32'h1234;
        tick();
        chk("rr1_first_a", mem_a, 32'h1234);
        tick();
        chk("rr1_ls_ack", {30'b0, if_ack, ls_ack}, 1);
        chk("rr1_ls_data", ls_rdata, 32'hDD);
        ls_req = 1'b0;
        tick();
        tick();
        chk("rr1_second_a", mem_a, 32'h100);
        tick();
        tick();
        tick();
        tick();
        chk("rr1_if_ack", {30'b0, if_ack, ls_ack}, 2);
        if_req = 1'b0;
        tick();
        // contention round 2: IF first
        if_req = 1'b1;
        ls_req = 1'b1;
        tick();
        chk("rr2_first_a", mem_a, 32'h100);
        tick();
        tick();
        tick();
        tick();
        chk("rr2_if_ack", {30'b0, if_ack, ls_ack}, 2);
        chk("rr2_if_data", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        tick();
        chk("rr2_second_a", mem_a, 32'h1234);
        tick();
        chk("rr2_ls_ack", {30'b0, if_ack, ls_ack}, 1);
        ls_req = 1'b0;
        tick();
        // LS half read wrapping the address space
        ls_req = 1'b1;
        ls_size = 2'b01;
        ls_addr = 32'hFFFF_FFFF;
        tick();
        chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        tick();
        chk("wrap_a1", mem_a, 32'h0);
        tick();
        chk("wrap_ack", {31'b0, ls_ack}, 1);
        chk("wrap_data", ls_rdata, 32'h0000_FF80);
        ls_req = 1'b0;
        tick();
        // LS word read with rdy low for 3 edges during byte 2
        ls_req = 1'b1;
        ls_size = 2'b10;
        ls_addr = 32'h100;
        tick();
        tick();
        chk("stall_a_start", mem_a, 32'h101);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_a_frozen", mem_a, 32'h101);
            chk("stall_no_ack", {30'b0, busy, ls_ack}, 2);
        end
        rdy = 1'b1;
        tick();
        chk("stall_a_resume", mem_a, 32'h102);
        tick();
        tick();
        chk("stall_ack", {31'b0, ls_ack}, 1);
        chk("stall_data", ls_rdata, 32'h0000_0513);
        ls_req = 1'b0;
        tick();
        // reset in the middle of a word write
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_addr = 32'h200;
        ls_wdata = 32'h4433_2211;
        tick();
        chk("wrst_dout0", {24'b0, mem_dout}, 32'h11);
        tick();
        chk("wrst_dout1", {24'b0, mem_dout}, 32'h22);
        rst = 1'b1;
        ls_req = 1'b0;
        ls_we = 1'b0;
        #1;
        chk("wrst_async", {30'b0, busy, mem_wr}, 0);
        tick();
        chk("wrst_no_ack", {31'b0, ls_ack}, 0);
        chk("wrst_ram0", {24'b0, ram[12'h200]}, 32'h11);
        chk("wrst_ram1", {24'b0, ram[12'h201]}, 32'h00);
        rst = 1'b0;
        tick();
        if_req = 1'b1;
        if_addr = 32'h100;
        tick();
        chk("post_rst_a", mem_a, 32'h100);
        tick();
        tick();
        tick();
        tick();
        chk("post_rst_ack", {31'b0, if_ack}, 1);
        chk("post_rst_data", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
